// File: rtl/trig_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// trig_seq_pkg : shared states, default widths and timing constants
// Rev 1.0
// ============================================================================
package trig_seq_pkg;

  localparam int N_CH_DEF  = 8;
  localparam int DUR_W_DEF = 11;
  localparam int DEL_W_DEF = 21;
  localparam int REP_W_DEF = 16;
  localparam int PER_W_DEF = 24;

  localparam int BLANK_CYC = 2;
  localparam int ARM_CYC   = 2;
  // Cycles from leaving WAIT/GAP to the next FIRE: CLR + ARM_CYC + FIRE.
  localparam int LEAD_CYC  = 1 + ARM_CYC + 1;
  localparam int PH_W      = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    ARM  = 3'd2,
    FIRE = 3'd3,
    WAIT = 3'd4,
    GAP  = 3'd5,
    DONE = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/trig_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// trig_seq_ctrl_if : sequencer <-> trigger channel bank signals
// Rev 1.0
// ============================================================================
interface trig_seq_ctrl_if #(
  parameter int N_CH  = trig_seq_pkg::N_CH_DEF,
  parameter int DUR_W = trig_seq_pkg::DUR_W_DEF,
  parameter int DEL_W = trig_seq_pkg::DEL_W_DEF
);
  logic [N_CH-1:0]       ch_rst;
  logic [N_CH-1:0]       ch_mark;
  logic [N_CH-1:0]       ch_go;
  logic [N_CH-1:0]       ch_stop;
  logic [N_CH*DUR_W-1:0] ch_dur;
  logic [N_CH*DEL_W-1:0] ch_del;
  logic [N_CH-1:0]       ch_done;

  modport master (
    output ch_rst, ch_mark, ch_go, ch_stop, ch_dur, ch_del,
    input  ch_done
  );

  modport slave (
    input  ch_rst, ch_mark, ch_go, ch_stop, ch_dur, ch_del,
    output ch_done
  );
endinterface
`default_nettype wire

// File: rtl/trig_seq_ctrl_timer.sv
`default_nettype none
// ============================================================================
// trig_period_timer : loadable down-counter, saturating at 0, with zero flag
// Rev 1.0
// ============================================================================
module trig_period_timer
  import trig_seq_pkg::*;
#(
  parameter int W = PER_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/trig_seq_ctrl.sv
`default_nettype none
// ============================================================================
// trig_seq_ctrl : fires every enabled trigger channel together, repeated per period
// Rev 1.0
// ============================================================================
module trig_seq_ctrl
  import trig_seq_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int DUR_W = DUR_W_DEF,
  parameter int DEL_W = DEL_W_DEF,
  parameter int REP_W = REP_W_DEF,
  parameter int PER_W = PER_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we_i,
  input  logic [$clog2(N_CH)-1:0] cfg_ch_i,
  input  logic [DUR_W-1:0]        cfg_dur_i,
  input  logic [DEL_W-1:0]        cfg_del_i,
  input  logic [N_CH-1:0]         ch_en_i,
  input  logic [REP_W-1:0]        rep_cnt_i,
  input  logic [PER_W-1:0]        period_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  trig_seq_ctrl_if.master         ch,
  output logic                    busy_o,
  output logic                    seq_done_o,
  output logic [REP_W-1:0]        shots_o,
  output logic                    overrun_o
);

  state_e           state_q, state_d;
  logic [N_CH-1:0]  en_q, en_d, rst_q, rst_d, mark_q, mark_d;
  logic [N_CH-1:0]  go_q, go_d, stop_q, stop_d;
  logic [REP_W-1:0] rep_q, rep_d, shots_q, shots_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic             busy_q, busy_d, done_q, done_d, ovr_q, ovr_d, zero_prev_q;
  logic             w_tmr_load, w_tmr_zero;
  logic [PER_W-1:0] w_load_val;

  logic [DUR_W-1:0]      dur_q [N_CH];
  logic [DEL_W-1:0]      del_q [N_CH];
  logic [N_CH*DUR_W-1:0] w_dur_pk;
  logic [N_CH*DEL_W-1:0] w_del_pk;

  always_ff @(posedge clk) begin
    if (cfg_we_i && state_q == IDLE) begin
      dur_q[cfg_ch_i] <= cfg_dur_i;
      del_q[cfg_ch_i] <= cfg_del_i;
    end
  end

  always_comb begin
    w_dur_pk = '0;
    w_del_pk = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_dur_pk[i*DUR_W +: DUR_W] = dur_q[i];
      w_del_pk[i*DEL_W +: DEL_W] = del_q[i];
    end
  end

  // Expire LEAD_CYC cycles early so the CLR/ARM lead-in lands the next FIRE
  // exactly one period after the previous one.
  assign w_load_val = (per_q > PER_W'(LEAD_CYC)) ? (per_q - PER_W'(LEAD_CYC + 1)) : '0;

  trig_period_timer #(.W(PER_W)) u_tmr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (w_tmr_load),
    .load_val_i (w_load_val),
    .zero_o     (w_tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    rep_d      = rep_q;
    per_d      = per_q;
    ph_d       = ph_q;
    shots_d    = shots_q;
    ovr_d      = ovr_q;
    stop_d     = '0;
    done_d     = 1'b0;
    w_tmr_load = 1'b0;
    case (state_q)
      IDLE: if (start_i && !abort_i) begin
        en_d    = ch_en_i;
        rep_d   = (rep_cnt_i == '0) ? REP_W'(1) : rep_cnt_i;
        per_d   = period_i;
        shots_d = '0;
        ovr_d   = 1'b0;
        if (ch_en_i == '0) done_d = 1'b1;
        else               state_d = CLR;
      end
      CLR: begin
        ph_d    = PH_W'(ARM_CYC - 1);
        state_d = ARM;
      end
      ARM: if (ph_q != '0) ph_d = ph_q - 1'b1;
           else            state_d = FIRE;
      FIRE: begin
        w_tmr_load = 1'b1;
        ph_d       = PH_W'(BLANK_CYC);
        state_d    = WAIT;
      end
      WAIT: if (ph_q != '0) begin
        ph_d = ph_q - 1'b1;
      end else if ((ch.ch_done & en_q) == en_q) begin
        shots_d = shots_q + 1'b1;
        if (shots_d == rep_q) begin
          state_d = DONE;
        end else if (w_tmr_zero) begin
          // Expiring exactly now is still on time; only an earlier expiry is late.
          state_d = CLR;
          ovr_d   = ovr_q | zero_prev_q;
        end else begin
          state_d = GAP;
        end
      end
      GAP:  if (w_tmr_zero) state_d = CLR;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
      shots_d = shots_q;
      ovr_d   = ovr_q;
      stop_d  = en_q;
    end
    if (state_d == DONE) done_d = 1'b1;
    busy_d = (state_d != IDLE);
    rst_d  = busy_d ? ~en_d : '1;
    mark_d = (state_d inside {ARM, FIRE, WAIT}) ? en_d : '0;
    go_d   = (state_d inside {FIRE, WAIT}) ? en_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      en_q        <= '0;
      rep_q       <= '0;
      per_q       <= '0;
      ph_q        <= '0;
      shots_q     <= '0;
      ovr_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rst_q       <= '1;
      mark_q      <= '0;
      go_q        <= '0;
      stop_q      <= '0;
      zero_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      rep_q       <= rep_d;
      per_q       <= per_d;
      ph_q        <= ph_d;
      shots_q     <= shots_d;
      ovr_q       <= ovr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rst_q       <= rst_d;
      mark_q      <= mark_d;
      go_q        <= go_d;
      stop_q      <= stop_d;
      zero_prev_q <= w_tmr_zero;
    end
  end

  assign ch.ch_rst  = rst_q;
  assign ch.ch_mark = mark_q;
  assign ch.ch_go   = go_q;
  assign ch.ch_stop = stop_q;
  assign ch.ch_dur  = w_dur_pk;
  assign ch.ch_del  = w_del_pk;
  assign busy_o     = busy_q;
  assign seq_done_o = done_q;
  assign shots_o    = shots_q;
  assign overrun_o  = ovr_q;

endmodule
`default_nettype wire
